// File: rtl/jc_phase_monitor.sv
// rtl/jc_phase_monitor.sv - Johnson counter phase decoder, succession checker and lock tracker
module jc_phase_monitor #(
    parameter int WIDTH    = 8,
    parameter int LOCK_LEN = 4,
    parameter int ERR_W    = 8,
    parameter int CYC_W    = 16,
    localparam int PW      = $clog2(2*WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] jc_in,
    input  logic             jc_valid,
    input  logic             clr_err,
    output logic [PW-1:0]    phase,
    output logic             phase_valid,
    output logic             illegal,
    output logic             seq_err,
    output logic             wrap_pulse,
    output logic             locked,
    output logic [ERR_W-1:0] err_count,
    output logic [CYC_W-1:0] cycle_count
);

    localparam int NPH = 2*WIDTH;
    localparam logic [PW-1:0] LAST_PH = PW'(NPH-1);

    typedef enum logic [1:0] {
        S_UNLOCKED = 2'd0,
        S_LOCKING  = 2'd1,
        S_LOCKED   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       run_q, run_d;
    logic             prev_valid;
    logic [PW-1:0]    ones;
    logic [WIDTH-1:0] inv;
    logic             legal;
    logic [PW-1:0]    dec;
    logic [PW-1:0]    succ;
    logic             seq_bad;
    logic             err_evt;

    // A legal code is a run of ones anchored at the LSB (MSB clear) or of
    // zeros anchored at the LSB (MSB set); the popcount then gives the phase.
    always_comb begin
        ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + PW'(jc_in[i]);
        end
        inv = ~jc_in;
        if (!jc_in[WIDTH-1]) begin
            legal = ((jc_in & (jc_in + WIDTH'(1))) == '0);
            dec   = ones;
        end else begin
            legal = ((inv & (inv + WIDTH'(1))) == '0);
            dec   = PW'(NPH - int'(ones));
        end
    end

    // phase always holds the last legal sample, so it doubles as the previous phase.
    assign succ    = (phase == LAST_PH) ? '0 : phase + PW'(1);
    assign seq_bad = prev_valid && (dec != succ);
    assign err_evt = jc_valid && (!legal || seq_bad);

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (jc_valid) begin
            case (state_q)
                S_UNLOCKED: begin
                    if (legal) begin
                        state_d = S_LOCKING;
                        run_d   = '0;
                    end
                end
                S_LOCKING: begin
                    if (!legal) begin
                        state_d = S_UNLOCKED;
                        run_d   = '0;
                    end else if (seq_bad) begin
                        run_d = '0;
                    end else if (run_q == 4'(LOCK_LEN-1)) begin
                        state_d = S_LOCKED;
                        run_d   = '0;
                    end else begin
                        run_d = run_q + 4'd1;
                    end
                end
                S_LOCKED: begin
                    if (!legal) begin
                        state_d = S_UNLOCKED;
                        run_d   = '0;
                    end else if (seq_bad) begin
                        state_d = S_LOCKING;
                        run_d   = '0;
                    end
                end
                default: begin
                    state_d = S_UNLOCKED;
                    run_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_UNLOCKED;
            run_q       <= '0;
            prev_valid  <= 1'b0;
            phase       <= '0;
            phase_valid <= 1'b0;
            illegal     <= 1'b0;
            seq_err     <= 1'b0;
            wrap_pulse  <= 1'b0;
            locked      <= 1'b0;
            err_count   <= '0;
            cycle_count <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            locked      <= (state_d == S_LOCKED);
            phase_valid <= 1'b0;
            illegal     <= 1'b0;
            seq_err     <= 1'b0;
            wrap_pulse  <= 1'b0;
            if (jc_valid) begin
                if (!legal) begin
                    illegal    <= 1'b1;
                    prev_valid <= 1'b0;
                end else begin
                    phase       <= dec;
                    phase_valid <= 1'b1;
                    prev_valid  <= 1'b1;
                    seq_err     <= seq_bad;
                    if (prev_valid && (phase == LAST_PH) && (dec == '0)) begin
                        wrap_pulse  <= 1'b1;
                        cycle_count <= cycle_count + CYC_W'(1);
                    end
                end
            end
            // A clear still records an error landing in the same cycle.
            if (clr_err) begin
                err_count <= err_evt ? ERR_W'(1) : '0;
            end else if (err_evt && (err_count != {ERR_W{1'b1}})) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_jc_phase_monitor.sv
// tb/tb_jc_phase_monitor.sv - directed self-checking bench for jc_phase_monitor
module tb_jc_phase_monitor;

    logic        clk;
    logic        reset;
    logic [7:0]  jc_in;
    logic        jc_valid;
    logic        clr_err;
    logic [3:0]  phase;
    logic        phase_valid;
    logic        illegal;
    logic        seq_err;
    logic        wrap_pulse;
    logic        locked;
    logic [7:0]  err_count;
    logic [15:0] cycle_count;

    int total = 0;
    int bad   = 0;
    int wraps;
    int seqs;

    jc_phase_monitor #(.WIDTH(8), .LOCK_LEN(4), .ERR_W(8), .CYC_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .jc_in       (jc_in),
        .jc_valid    (jc_valid),
        .clr_err     (clr_err),
        .phase       (phase),
        .phase_valid (phase_valid),
        .illegal     (illegal),
        .seq_err     (seq_err),
        .wrap_pulse  (wrap_pulse),
        .locked      (locked),
        .err_count   (err_count),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input logic [7:0] d, input logic c);
        @(negedge clk);
        jc_in    = d;
        jc_valid = 1'b1;
        clr_err  = c;
        @(posedge clk);
        #1;
        jc_valid = 1'b0;
        clr_err  = 1'b0;
    endtask

    function automatic logic [7:0] code_of(input int p);
        logic [7:0] ff;
        ff = 8'hFF;
        if (p < 8) return ff >> (8 - p);
        return ff << (p - 8);
    endfunction

    initial begin
        reset = 1'b0; jc_in = '0; jc_valid = 1'b0; clr_err = 1'b0;
        #12;
        chk("rst_phase", phase, 0);
        chk("rst_pv", phase_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err", err_count, 0);
        chk("rst_cyc", cycle_count, 0);
        @(negedge clk); reset = 1'b1;

        // lock-in run 0x00..0x0F
        for (int p = 0; p <= 4; p++) begin
            sample(code_of(p), 1'b0);
            chk("lock_phase", phase, p);
            chk("lock_pv", phase_valid, 1);
            chk("lock_seq", seq_err, 0);
            if (p == 3) chk("lock_early", locked, 0);
        end
        chk("lock_locked", locked, 1);
        chk("lock_err", err_count, 0);

        // illegal while locked
        sample(8'h05, 1'b0);
        chk("ill_flag", illegal, 1);
        chk("ill_phase_hold", phase, 4);
        chk("ill_pv", phase_valid, 0);
        chk("ill_locked", locked, 0);
        chk("ill_err", err_count, 1);
        sample(8'h1F, 1'b0);
        chk("after_ill_seq", seq_err, 0);
        chk("after_ill_phase", phase, 5);
        chk("after_ill_illegal", illegal, 0);

        // succession errors, then relock
        sample(8'h03, 1'b0);
        chk("seq1_flag", seq_err, 1);
        chk("seq1_err", err_count, 2);
        sample(8'h0F, 1'b0);
        chk("seq2_flag", seq_err, 1);
        chk("seq2_phase", phase, 4);
        chk("seq2_err", err_count, 3);
        chk("seq2_locked", locked, 0);
        sample(8'h1F, 1'b0); chk("relock_a", locked, 0);
        sample(8'h3F, 1'b0); chk("relock_b", locked, 0);
        sample(8'h7F, 1'b0); chk("relock_c", locked, 0);
        sample(8'hFF, 1'b0);
        chk("relock_locked", locked, 1);
        chk("relock_phase", phase, 8);

        // full cycle from 0x00 (phase 8 -> 0 is itself a succession error)
        sample(8'h00, 1'b0);
        chk("cyc_start_seq", seq_err, 1);
        chk("cyc_start_err", err_count, 4);
        chk("cyc_start_locked", locked, 0);
        wraps = 0; seqs = 0;
        for (int p = 1; p <= 16; p++) begin
            sample(code_of(p % 16), 1'b0);
            wraps += int'(wrap_pulse);
            seqs  += int'(seq_err);
            if (p == 15) chk("cyc_phase15", phase, 15);
        end
        chk("cyc_wrap_once", wraps, 1);
        chk("cyc_wrap_last", wrap_pulse, 1);
        chk("cyc_seq_none", seqs, 0);
        chk("cyc_count1", cycle_count, 1);
        chk("cyc_err_hold", err_count, 4);
        chk("cyc_locked", locked, 1);
        for (int c = 0; c < 2; c++) begin
            for (int p = 1; p <= 16; p++) sample(code_of(p % 16), 1'b0);
        end
        chk("cyc_count3", cycle_count, 3);
        chk("cyc_err_hold3", err_count, 4);

        // saturation and clear
        for (int i = 0; i < 300; i++) sample(8'h55, 1'b0);
        chk("sat_err", err_count, 255);
        chk("sat_illegal", illegal, 1);
        chk("sat_phase_hold", phase, 0);
        chk("sat_locked", locked, 0);
        @(negedge clk); clr_err = 1'b1;
        @(posedge clk); #1; clr_err = 1'b0;
        chk("clr_alone", err_count, 0);
        sample(8'h55, 1'b1);
        chk("clr_with_err", err_count, 1);

        // async reset while locked, with a valid sample pending
        for (int p = 0; p <= 4; p++) sample(code_of(p), 1'b0);
        chk("pre_rst_locked", locked, 1);
        @(negedge clk);
        jc_in = 8'h1F; jc_valid = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("arst_phase", phase, 0);
        chk("arst_pv", phase_valid, 0);
        chk("arst_locked", locked, 0);
        chk("arst_err", err_count, 0);
        chk("arst_cyc", cycle_count, 0);
        @(negedge clk); jc_valid = 1'b0; reset = 1'b1;
        sample(8'h3F, 1'b0);
        chk("post_rst_phase", phase, 6);
        chk("post_rst_pv", phase_valid, 1);
        chk("post_rst_seq", seq_err, 0);
        chk("post_rst_locked", locked, 0);
        sample(8'h7F, 1'b0); chk("post_rst_a", locked, 0);
        sample(8'hFF, 1'b0); chk("post_rst_b", locked, 0);
        sample(8'hFE, 1'b0); chk("post_rst_c", locked, 0);
        sample(8'hFC, 1'b0);
        chk("post_rst_locked4", locked, 1);
        chk("post_rst_phase10", phase, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
